// File: rtl/siganfu_pkg.sv
// siganfu_pkg
//   Shared encodings for the siganfu fire-control slice.
//   - Gun controller state encodings as seen on gun_state.
//   - Fire-control FSM state enum (value is exported on fc_state).
//   - Default timing/limit constants used as top-level parameter defaults.
package siganfu_pkg;

   localparam logic [2:0] GUN_IDLE     = 3'b000;
   localparam logic [2:0] GUN_OVERHEAT = 3'b100;
   localparam logic [2:0] GUN_DOWNFALL = 3'b101;

   typedef enum logic [2:0] {
      FC_SEARCH  = 3'd0,
      FC_TRACK   = 3'd1,
      FC_IDENT   = 3'd2,
      FC_ARMED   = 3'd3,
      FC_ENGAGE  = 3'd4,
      FC_HOLDOFF = 3'd5
   } fc_state_e;

   localparam int DEF_LOCK_CYCLES    = 8;
   localparam int DEF_IFF_TIMEOUT    = 32;
   localparam int DEF_BURST_MAX      = 10;
   localparam int DEF_HOLDOFF_CYCLES = 4;

endpackage

// File: rtl/siganfu_iff_client.sv
// siganfu_iff_client
//   IFF query handshake: holds iff_req/iff_id from start until ack, timeout
//   or abort, and pulses iff_fault for one cycle when the query times out.
// Ports
//   sysclk, reboot_n   clock, synchronous active-low reset
//   start, start_id    begin a query for start_id (ignored when abort is high)
//   abort              drop any query in progress
//   iff_ack            response strobe from the IFF unit
//   iff_req, iff_id    registered request and id under query
//   iff_fault          registered 1-cycle timeout pulse
//   timeout_hit        combinational: this cycle ends the query by timeout
module siganfu_iff_client #(
   parameter int IFF_TIMEOUT = 32
) (
   input  logic       sysclk,
   input  logic       reboot_n,
   input  logic       start,
   input  logic [7:0] start_id,
   input  logic       abort,
   input  logic       iff_ack,
   output logic       iff_req,
   output logic [7:0] iff_id,
   output logic       iff_fault,
   output logic       timeout_hit
);

   localparam int              TW   = $clog2(IFF_TIMEOUT + 1);
   localparam logic [TW-1:0]   TMAX = TW'(IFF_TIMEOUT - 1);

   logic          req_q, req_d;
   logic [7:0]    id_q, id_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          fault_q, fault_d;

   // An ack arriving on the last timer cycle takes precedence over the timeout.
   assign timeout_hit = req_q & ~iff_ack & (timer_q == TMAX);

   always_comb begin
      req_d   = req_q;
      id_d    = id_q;
      timer_d = timer_q;
      fault_d = 1'b0;
      if (abort) begin
         req_d = 1'b0;
      end else if (start) begin
         req_d   = 1'b1;
         id_d    = start_id;
         timer_d = '0;
      end else if (req_q) begin
         if (iff_ack) begin
            req_d = 1'b0;
         end else if (timer_q == TMAX) begin
            req_d   = 1'b0;
            fault_d = 1'b1;
         end else begin
            timer_d = timer_q + TW'(1);
         end
      end
   end

   always_ff @(posedge sysclk) begin
      if (!reboot_n) begin
         req_q   <= 1'b0;
         id_q    <= '0;
         timer_q <= '0;
         fault_q <= 1'b0;
      end else begin
         req_q   <= req_d;
         id_q    <= id_d;
         timer_q <= timer_d;
         fault_q <= fault_d;
      end
   end

   assign iff_req   = req_q;
   assign iff_id    = id_q;
   assign iff_fault = fault_q;

endmodule

// File: rtl/siganfu_fire_control.sv
// siganfu_fire_control
//   Fire-control front end for the siganfu gun: qualifies radar contacts
//   into a lock, runs the IFF query, arms and meters trigger pulls.
// Ports
//   sysclk, reboot_n                   clock, synchronous active-low reset
//   contact_valid, contact_id          radar track
//   iff_req/iff_id/iff_ack/iff_friend  IFF handshake
//   operator_trigger, mode_select      operator controls (mode 0 single, 1 auto)
//   gun_state, gun_fire_trigger, gun_alert   gun controller status
//   target_locked, is_enemy, fire_command, firing_mode   commands to gun
//   fc_state, shots_fired, iff_fault   status
// Build option: FC_CONSERVE_EN -- with gun_alert high, firing_mode latches as
//   single; an alert rising during an auto engagement ends it at the next shot.
//
// state   | meaning
// SEARCH  | no track; outputs cleared
// TRACK   | counting consecutive cycles of the same contact id
// IDENT   | locked, IFF query outstanding
// ARMED   | enemy confirmed, waiting for a fresh trigger pull
// ENGAGE  | fire_command asserted, metering gun shots
// HOLDOFF | post-engagement dwell before re-arm or release
module siganfu_fire_control
   import siganfu_pkg::*;
#(
   parameter int LOCK_CYCLES    = DEF_LOCK_CYCLES,
   parameter int IFF_TIMEOUT    = DEF_IFF_TIMEOUT,
   parameter int BURST_MAX      = DEF_BURST_MAX,
   parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
   input  logic        sysclk,
   input  logic        reboot_n,
   input  logic        contact_valid,
   input  logic [7:0]  contact_id,
   output logic        iff_req,
   output logic [7:0]  iff_id,
   input  logic        iff_ack,
   input  logic        iff_friend,
   input  logic        operator_trigger,
   input  logic        mode_select,
   input  logic [2:0]  gun_state,
   input  logic        gun_fire_trigger,
   input  logic        gun_alert,
   output logic        target_locked,
   output logic        is_enemy,
   output logic        fire_command,
   output logic        firing_mode,
   output logic [2:0]  fc_state,
   output logic [15:0] shots_fired,
   output logic        iff_fault
);

   localparam int LW = $clog2(LOCK_CYCLES + 1);
   localparam int BW = $clog2(BURST_MAX + 1);
   localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

   fc_state_e     state_q, state_d;
   logic [7:0]    id_q, id_d;
   logic [LW-1:0] lock_q, lock_d;
   logic [BW-1:0] burst_q, burst_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          tl_q, tl_d, en_q, en_d, fc_q, fc_d, fm_q, fm_d;
   logic          trig_ok_q, trig_ok_d;
   logic          gft_prev_q;
   logic [15:0]   shots_q, shots_d;

   logic          gft_rise, contact_lost, mode_eff, alert_end;
   logic          iff_start, iff_abort, iff_timeout;
   logic [LW-1:0] lock_inc;
   logic [BW-1:0] burst_inc;

   assign gft_rise     = gun_fire_trigger & ~gft_prev_q;
   assign contact_lost = ~contact_valid | (contact_id != id_q);
   assign lock_inc     = lock_q + LW'(1);
   assign burst_inc    = burst_q + BW'(gft_rise);

`ifdef FC_CONSERVE_EN
   logic alert_prev_q, alert_stop_q, alert_stop_d;

   always_comb begin
      alert_stop_d = alert_stop_q;
      if (state_q != FC_ENGAGE)
         alert_stop_d = 1'b0;
      else if (gun_alert && !alert_prev_q && fm_q)
         alert_stop_d = 1'b1;
   end

   always_ff @(posedge sysclk) begin
      if (!reboot_n) begin
         alert_prev_q <= 1'b0;
         alert_stop_q <= 1'b0;
      end else begin
         alert_prev_q <= gun_alert;
         alert_stop_q <= alert_stop_d;
      end
   end

   assign mode_eff  = mode_select & ~gun_alert;
   assign alert_end = alert_stop_q & gft_rise;
`else
   logic unused_alert;
   assign unused_alert = gun_alert;
   assign mode_eff     = mode_select;
   assign alert_end    = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      lock_d    = lock_q;
      burst_d   = burst_q;
      hold_d    = hold_q;
      tl_d      = tl_q;
      en_d      = en_q;
      fc_d      = fc_q;
      fm_d      = fm_q;
      trig_ok_d = trig_ok_q;
      shots_d   = (gft_rise && shots_q != 16'hFFFF) ? shots_q + 16'd1 : shots_q;
      iff_start = 1'b0;
      iff_abort = 1'b0;

      if (gun_state == GUN_DOWNFALL ||
          (contact_lost && state_q != FC_SEARCH && state_q != FC_HOLDOFF)) begin
         state_d   = FC_SEARCH;
         tl_d      = 1'b0;
         en_d      = 1'b0;
         fc_d      = 1'b0;
         fm_d      = 1'b0;
         iff_abort = 1'b1;
      end else begin
         case (state_q)
            FC_SEARCH: if (contact_valid) begin
               id_d    = contact_id;
               lock_d  = LW'(1);
               state_d = FC_TRACK;
            end
            FC_TRACK: begin
               lock_d = lock_inc;
               if (lock_inc == LW'(LOCK_CYCLES)) begin
                  tl_d      = 1'b1;
                  iff_start = 1'b1;
                  state_d   = FC_IDENT;
               end
            end
            FC_IDENT: if (iff_ack || iff_timeout) begin
               // A timeout is treated exactly like a friendly verdict.
               en_d      = iff_ack & ~iff_friend;
               trig_ok_d = 1'b0;
               hold_d    = HW'(HOLDOFF_CYCLES - 1);
               state_d   = (iff_ack && !iff_friend) ? FC_ARMED : FC_HOLDOFF;
            end
            FC_ARMED: begin
               // The trigger must be seen low after entry so a held trigger never fires.
               if (!operator_trigger) begin
                  trig_ok_d = 1'b1;
               end else if (trig_ok_q) begin
                  fm_d    = mode_eff;
                  burst_d = '0;
                  fc_d    = 1'b1;
                  state_d = FC_ENGAGE;
               end
            end
            FC_ENGAGE: begin
               burst_d = burst_inc;
               if (fm_q ? (!operator_trigger || burst_inc == BW'(BURST_MAX) ||
                           gun_state == GUN_OVERHEAT || alert_end)
                        : gft_rise) begin
                  fc_d    = 1'b0;
                  hold_d  = HW'(HOLDOFF_CYCLES - 1);
                  state_d = FC_HOLDOFF;
               end
            end
            FC_HOLDOFF: begin
               if (hold_q != '0) begin
                  hold_d = hold_q - HW'(1);
               end else if (contact_valid && contact_id == id_q && en_q) begin
                  trig_ok_d = 1'b0;
                  state_d   = FC_ARMED;
               end else begin
                  tl_d    = 1'b0;
                  en_d    = 1'b0;
                  fm_d    = 1'b0;
                  state_d = FC_SEARCH;
               end
            end
            default: state_d = FC_SEARCH;
         endcase
      end
   end

   always_ff @(posedge sysclk) begin
      if (!reboot_n) begin
         state_q    <= FC_SEARCH;
         id_q       <= '0;
         lock_q     <= '0;
         burst_q    <= '0;
         hold_q     <= '0;
         tl_q       <= 1'b0;
         en_q       <= 1'b0;
         fc_q       <= 1'b0;
         fm_q       <= 1'b0;
         trig_ok_q  <= 1'b0;
         gft_prev_q <= 1'b0;
         shots_q    <= '0;
      end else begin
         state_q    <= state_d;
         id_q       <= id_d;
         lock_q     <= lock_d;
         burst_q    <= burst_d;
         hold_q     <= hold_d;
         tl_q       <= tl_d;
         en_q       <= en_d;
         fc_q       <= fc_d;
         fm_q       <= fm_d;
         trig_ok_q  <= trig_ok_d;
         gft_prev_q <= gun_fire_trigger;
         shots_q    <= shots_d;
      end
   end

   siganfu_iff_client #(.IFF_TIMEOUT(IFF_TIMEOUT)) u_iff (
      .sysclk      (sysclk),
      .reboot_n    (reboot_n),
      .start       (iff_start),
      .start_id    (contact_id),
      .abort       (iff_abort),
      .iff_ack     (iff_ack),
      .iff_req     (iff_req),
      .iff_id      (iff_id),
      .iff_fault   (iff_fault),
      .timeout_hit (iff_timeout)
   );

   assign target_locked = tl_q;
   assign is_enemy      = en_q;
   assign fire_command  = fc_q;
   assign firing_mode   = fm_q;
   assign fc_state      = state_q;
   assign shots_fired   = shots_q;

endmodule
